// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, data RAM wait
// handling, operand forwarding selects and saturating performance counters.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic             ex_have_inst,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wR,
  input  logic [4:0]       mem_wR,
  input  logic [4:0]       wb_wR,
  input  logic             mem_have_inst,
  input  logic             mem_rf_we,
  input  logic             wb_have_inst,
  input  logic             wb_rf_we,
  input  logic             ex_branch_taken,
  input  logic             mem_ram_req,
  input  logic             mem_ram_ack,
  output logic             pipeline_stop,
  output logic             id_ex_hazard,
  output logic             if_id_flush,
  output logic             mem_stall,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;

  assign load_use = ex_have_inst & ex_rf_we & ex_is_load & (ex_wR != 5'd0) &
                    ((id_re1 & (id_rs1 == ex_wR)) | (id_re2 & (id_rs2 == ex_wR)));

  // Youngest producer wins; a load in EX cannot forward yet.
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'd0;
    if (rs != 5'd0) begin
      if (ex_have_inst && ex_rf_we && !ex_is_load && ex_wR == rs) sel = 2'd1;
      else if (mem_have_inst && mem_rf_we && mem_wR == rs)        sel = 2'd2;
      else if (wb_have_inst && wb_rf_we && wb_wR == rs)           sel = 2'd3;
    end
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_ram_req && !mem_ram_ack) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ram_ack)                 state_nxt = RUN;
      default:                                   state_nxt = RUN;
    endcase
  end

  // Controls are gated by rst_n so they drop the instant reset asserts.
  always_comb begin
    pipeline_stop = 1'b0;
    id_ex_hazard  = 1'b0;
    if_id_flush   = 1'b0;
    mem_stall     = 1'b0;
    fwd_sel1      = 2'd0;
    fwd_sel2      = 2'd0;
    if (rst_n) begin
      fwd_sel1 = fwd_pick(id_rs1);
      fwd_sel2 = fwd_pick(id_rs2);
      case (state)
        RUN: begin
          if (mem_ram_req && !mem_ram_ack) begin
            mem_stall     = 1'b1;
            pipeline_stop = 1'b1;
          end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_hazard = 1'b1;
          end else if (load_use) begin
            pipeline_stop = 1'b1;
            id_ex_hazard  = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ram_ack) begin
            mem_stall     = 1'b1;
            pipeline_stop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (pipeline_stop && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != '1)   flush_cnt <= flush_cnt + CNT_W'(1);
      if (state == RUN && state_nxt == MEM_WAIT)
        wait_cnt <= '0;
      else if (state == MEM_WAIT && wait_cnt != WAIT_W'(TIMEOUT))
        wait_cnt <= wait_cnt + WAIT_W'(1);
      // Sticky: the counter reaching TIMEOUT on this edge flags the error.
      if (state == MEM_WAIT && wait_cnt == WAIT_W'(TIMEOUT - 1))
        mem_timeout <= 1'b1;
    end
  end

endmodule
